// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: Zicsr funct3 encodings,
// FSM state encoding and the read-only address field value.
// Ports: none (package).
package csr_pkg;

  // Zicsr funct3 encodings
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Operation field (funct3[1:0]); 2'b00 is not a CSR operation
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // addr[11:10] value marking a read-only CSR
  localparam logic [1:0] RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [1:0] op_kind(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic is_imm(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundle of the request, CSR-file and response signals of the CSR access unit.
// Ports: slave = the access unit's view; master = the surrounding pipeline
// and CSR file (drives requests and read data, consumes writes and responses).
interface csr_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  // request from execute
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [CSR_AW-1:0] req_csr_addr;
  logic [XLEN-1:0]   req_rs1_data;
  logic [4:0]        req_rs1_idx;
  logic [4:0]        req_rd_idx;
  // CSR register file
  logic [CSR_AW-1:0] csr_addr;
  logic [XLEN-1:0]   csr_data;
  logic              csr_write_en;
  logic [CSR_AW-1:0] csr_wb_addr;
  logic [XLEN-1:0]   csr_wb_data;
  // response to writeback
  logic              resp_valid;
  logic              resp_ready;
  logic [4:0]        resp_rd_idx;
  logic [XLEN-1:0]   resp_rd_data;
  logic              resp_rd_we;
  logic              resp_illegal;

  modport slave (
    input  req_valid, req_funct3, req_csr_addr, req_rs1_data, req_rs1_idx, req_rd_idx,
    output req_ready,
    output csr_addr, csr_write_en, csr_wb_addr, csr_wb_data,
    input  csr_data,
    output resp_valid, resp_rd_idx, resp_rd_data, resp_rd_we, resp_illegal,
    input  resp_ready
  );

  modport master (
    output req_valid, req_funct3, req_csr_addr, req_rs1_data, req_rs1_idx, req_rd_idx,
    input  req_ready,
    input  csr_addr, csr_write_en, csr_wb_addr, csr_wb_data,
    output csr_data,
    input  resp_valid, resp_rd_idx, resp_rd_data, resp_rd_we, resp_illegal,
    output resp_ready
  );

endinterface

// File: rtl/csr_alu.sv
// Zicsr read-modify-write datapath: new value and whether a write is intended.
// Latency: combinational. Backpressure: none.
// Ports: op_sel (funct3[1:0]), old_val, op_val, rs1_idx -> new_val, write_intent.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op_sel,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] op_val,
  input  logic [4:0]      rs1_idx,
  output logic [XLEN-1:0] new_val,
  output logic            write_intent
);

  always_comb begin
    new_val = old_val;
    case (op_sel)
      OP_RW:   new_val = op_val;
      OP_RS:   new_val = old_val | op_val;
      OP_RC:   new_val = old_val & ~op_val;
      default: new_val = old_val;
    endcase
    // set/clear with x0 / zimm==0 must not touch the CSR
    write_intent = (op_sel == OP_RW) || (rs1_idx != 5'd0);
  end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator for the CSR file: one Zicsr op at a time, read then optional write,
// old value returned. Latency: write N+2 / resp N+3, or resp N+2 with no write.
// Backpressure: req_ready only in IDLE; response held until resp_ready.
// Ports: clk, rst (async, active low), bus (csr_access_unit_if.slave).
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CSR_AW   = 12,
  parameter bit RO_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  csr_access_unit_if.slave    bus
);

  state_t            state_q, state_d;
  logic [1:0]        op_sel_q;
  logic [CSR_AW-1:0] addr_q;
  logic [4:0]        rd_q;
  logic [4:0]        rs1_idx_q;
  logic [XLEN-1:0]   operand_q;
  logic [XLEN-1:0]   old_q;
  logic [CSR_AW-1:0] wb_addr_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              illegal_q;
  logic              rd_we_q;

  logic              accept;
  logic [XLEN-1:0]   new_val;
  logic              write_intent;
  logic              illegal_c;
  logic              do_write;

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op_sel       (op_sel_q),
    .old_val      (bus.csr_data),
    .op_val       (operand_q),
    .rs1_idx      (rs1_idx_q),
    .new_val      (new_val),
    .write_intent (write_intent)
  );

  // Only meaningful in READ, where csr_data reflects addr_q.
  assign illegal_c = (op_sel_q == 2'b00) ||
                     (RO_CHECK && write_intent && (addr_q[CSR_AW-1 -: 2] == RO_FIELD));
  assign do_write  = write_intent && !illegal_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  state_d = do_write ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (bus.resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Latched request fields and results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_sel_q  <= 2'b00;
      addr_q    <= '0;
      rd_q      <= 5'd0;
      rs1_idx_q <= 5'd0;
      operand_q <= '0;
      old_q     <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
      rd_we_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_sel_q  <= op_kind(bus.req_funct3);
        addr_q    <= bus.req_csr_addr;
        rd_q      <= bus.req_rd_idx;
        rs1_idx_q <= bus.req_rs1_idx;
        operand_q <= is_imm(bus.req_funct3) ? {{(XLEN-5){1'b0}}, bus.req_rs1_idx}
                                            : bus.req_rs1_data;
      end
      if (state_q == ST_READ) begin
        old_q     <= bus.csr_data;
        illegal_q <= illegal_c;
        rd_we_q   <= !illegal_c && (rd_q != 5'd0);
        // write port keeps its previous contents when no write follows
        if (do_write) begin
          wb_addr_q <= addr_q;
          wb_data_q <= new_val;
        end
      end
    end
  end

  // Output decode, purely from the state register
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.csr_write_en = 1'b0;
    bus.resp_valid   = 1'b0;
    case (state_q)
      ST_IDLE:  bus.req_ready    = 1'b1;
      ST_WRITE: bus.csr_write_en = 1'b1;
      ST_RESP:  bus.resp_valid   = 1'b1;
      default: ;
    endcase
  end

  assign bus.csr_addr     = addr_q;
  assign bus.csr_wb_addr  = wb_addr_q;
  assign bus.csr_wb_data  = wb_data_q;
  assign bus.resp_rd_idx  = rd_q;
  assign bus.resp_rd_data = old_q;
  assign bus.resp_rd_we   = rd_we_q;
  assign bus.resp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_access_unit_if #(.XLEN(32), .CSR_AW(12)) bus();

  csr_access_unit #(.XLEN(32), .CSR_AW(12), .RO_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // CSR file model: combinational read, commit on the falling edge
  logic [31:0] file_mem [4096] = '{default: 32'h0};
  logic [31:0] model_mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'h0;
  logic [31:0] pl_data = 32'h0;
  int          write_cnt = 0;
  int          total = 0;
  int          bad = 0;

  assign bus.csr_data = file_mem[bus.csr_addr];

  always @(negedge clk) begin
    if (bus.csr_write_en) begin
      file_mem[bus.csr_wb_addr] <= bus.csr_wb_data;
      write_cnt <= write_cnt + 1;
    end else if (pl_en) begin
      file_mem[pl_addr] <= pl_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: Zicsr rules written directly from the instruction semantics
  function automatic void model(input logic [2:0] f3, input logic [11:0] addr,
                                input logic [31:0] rs1d, input logic [4:0] rs1i,
                                input logic [31:0] old, output logic wr,
                                output logic ill, output logic [31:0] nv);
    logic [1:0]  mode;
    logic [31:0] op;
    logic        writes;
    mode   = f3[1:0];
    op     = f3[2] ? {27'b0, rs1i} : rs1d;
    writes = (mode == 2'd1) || (rs1i != 5'd0);
    ill    = (mode == 2'd0) || (writes && addr >= 12'hC00);
    wr     = writes && !ill;
    case (mode)
      2'd1:    nv = op;
      2'd2:    nv = old | op;
      2'd3:    nv = old & ~op;
      default: nv = old;
    endcase
  endfunction

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    model_mem[a] = v;
    pl_addr = a;
    pl_data = v;
    pl_en = 1'b1;
    @(negedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] rs1d, input logic [4:0] rs1i,
                       input logic [4:0] rd, input int stall);
    logic [31:0] old, exp_new, wr_data;
    logic [11:0] wr_addr;
    logic        exp_wr, exp_ill, exp_we, ready_leak, stable;
    logic [38:0] exp_resp, snap;
    int          n, wc0, resp_k, wr_k, exp_resp_k, exp_wr_k;

    old = model_mem[addr];
    model(f3, addr, rs1d, rs1i, old, exp_wr, exp_ill, exp_new);
    exp_we   = !exp_ill && (rd != 5'd0);
    exp_resp = {old, rd, exp_we, exp_ill};

    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_wait: actual=%b required=1", name, bus.req_ready);
    end

    bus.req_funct3   = f3;
    bus.req_csr_addr = addr;
    bus.req_rs1_data = rs1d;
    bus.req_rs1_idx  = rs1i;
    bus.req_rd_idx   = rd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_rs1_data = $urandom;
    bus.req_rs1_idx  = 5'($urandom);
    wc0 = write_cnt;

    resp_k = 0; wr_k = 0; ready_leak = 1'b0;
    wr_addr = '0; wr_data = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.req_ready) ready_leak = 1'b1;
      if (bus.csr_write_en && wr_k == 0) begin
        wr_k = k;
        wr_addr = bus.csr_wb_addr;
        wr_data = bus.csr_wb_data;
      end
      if (bus.resp_valid) begin
        resp_k = k;
        break;
      end
    end

    exp_resp_k = exp_wr ? 3 : 2;
    exp_wr_k   = exp_wr ? 2 : 0;
    total++;
    if (resp_k != exp_resp_k) begin
      bad++;
      $display("FAIL %s resp_latency: actual=%0d required=%0d", name, resp_k, exp_resp_k);
    end
    total++;
    if (wr_k != exp_wr_k) begin
      bad++;
      $display("FAIL %s write_cycle: actual=%0d required=%0d", name, wr_k, exp_wr_k);
    end
    if (exp_wr) begin
      total++;
      if ({wr_addr, wr_data} !== {addr, exp_new}) begin
        bad++;
        $display("FAIL %s write_data: actual=%h/%h required=%h/%h",
                 name, wr_addr, wr_data, addr, exp_new);
      end
    end
    total++;
    if (ready_leak !== 1'b0) begin
      bad++;
      $display("FAIL %s req_ready_busy: actual=1 required=0", name);
    end
    snap = {bus.resp_rd_data, bus.resp_rd_idx, bus.resp_rd_we, bus.resp_illegal};
    total++;
    if (snap !== exp_resp) begin
      bad++;
      $display("FAIL %s resp_fields: actual data=%h rd=%0d we=%b ill=%b required data=%h rd=%0d we=%b ill=%b",
               name, snap[38:7], snap[6:2], snap[1], snap[0], old, rd, exp_we, exp_ill);
    end

    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.req_ready ||
          {bus.resp_rd_data, bus.resp_rd_idx, bus.resp_rd_we, bus.resp_illegal} !== snap)
        stable = 1'b0;
    end
    if (stall > 0) begin
      total++;
      if (stable !== 1'b1) begin
        bad++;
        $display("FAIL %s resp_hold: actual=unstable required=stable", name);
      end
    end

    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL %s after_handshake: actual ready/valid=%b%b required=10",
               name, bus.req_ready, bus.resp_valid);
    end

    if (exp_wr) model_mem[addr] = exp_new;
    total++;
    if (file_mem[addr] !== model_mem[addr] || (write_cnt - wc0) != int'(exp_wr)) begin
      bad++;
      $display("FAIL %s file_state: actual=%h writes=%0d required=%h writes=%0d",
               name, file_mem[addr], write_cnt - wc0, model_mem[addr], int'(exp_wr));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.csr_write_en, bus.csr_addr, bus.csr_wb_addr,
         bus.csr_wb_data, bus.resp_rd_data, bus.resp_rd_idx, bus.resp_rd_we,
         bus.resp_illegal} !== {1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: actual ready=%b valid=%b we=%b addr=%h wbaddr=%h wbdata=%h rdata=%h required ready=1 rest=0",
               bus.req_ready, bus.resp_valid, bus.csr_write_en, bus.csr_addr,
               bus.csr_wb_addr, bus.csr_wb_data, bus.resp_rd_data);
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    preload(12'h340, 32'h12345678);
    do_op("csrrw", F3_CSRRW, 12'h340, 32'hDEADBEEF, 5'd7, 5'd5, 0);
    preload(12'h300, 32'hCAFE0001);
    do_op("csrrs_x0", F3_CSRRS, 12'h300, 32'hFFFFFFFF, 5'd0, 5'd9, 0);
    preload(12'h300, 32'h000000FF);
    do_op("csrrci", F3_CSRRCI, 12'h300, 32'h0, 5'd5, 5'd1, 0);
    preload(12'h300, 32'h00000010);
    do_op("csrrsi", F3_CSRRSI, 12'h300, 32'h0, 5'd3, 5'd2, 0);
    do_op("csrrc_reg", F3_CSRRC, 12'h340, 32'h0000FFFF, 5'd4, 5'd6, 0);
    do_op("csrrwi_rd0", F3_CSRRWI, 12'h341, 32'h0, 5'd17, 5'd0, 0);
  endtask

  task automatic test_read_only();
    preload(12'hC00, 32'h00A5A5A5);
    do_op("ro_write", F3_CSRRW, 12'hC00, 32'h11111111, 5'd3, 5'd8, 0);
    do_op("ro_read", F3_CSRRS, 12'hC00, 32'h22222222, 5'd0, 5'd8, 0);
    do_op("bad_f3", 3'b000, 12'h340, 32'h33333333, 5'd2, 5'd4, 0);
  endtask

  task automatic test_backpressure();
    do_op("stall4", F3_CSRRS, 12'h340, 32'h80000000, 5'd1, 5'd11, 4);
  endtask

  task automatic test_reset_in_write();
    int wc0;
    preload(12'h342, 32'h0BADF00D);
    @(negedge clk);
    bus.req_funct3   = F3_CSRRW;
    bus.req_csr_addr = 12'h342;
    bus.req_rs1_data = 32'h11112222;
    bus.req_rs1_idx  = 5'd1;
    bus.req_rd_idx   = 5'd3;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wc0 = write_cnt;
    @(posedge clk);
    #1;
    total++;
    if (bus.csr_write_en !== 1'b1) begin
      bad++;
      $display("FAIL rst_write_pre: actual=%b required=1", bus.csr_write_en);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({bus.csr_write_en, bus.resp_valid, bus.req_ready} !== 3'b001) begin
      bad++;
      $display("FAIL rst_write_drop: actual we/valid/ready=%b%b%b required=001",
               bus.csr_write_en, bus.resp_valid, bus.req_ready);
    end
    repeat (2) @(negedge clk);
    total++;
    if (file_mem[12'h342] !== 32'h0BADF00D || write_cnt != wc0) begin
      bad++;
      $display("FAIL rst_write_file: actual=%h writes=%0d required=0badf00d writes=0",
               file_mem[12'h342], write_cnt - wc0);
    end
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [11:0] pool [6];
    logic [2:0]  f3;
    logic [4:0]  rs1i, rd;
    pool[0] = 12'h300; pool[1] = 12'h340; pool[2] = 12'h7C0;
    pool[3] = 12'hC00; pool[4] = 12'hC01; pool[5] = 12'hF11;
    for (int i = 0; i < 6; i++) preload(pool[i], $urandom);
    for (int i = 0; i < 40; i++) begin
      f3   = 3'($urandom_range(0, 7));
      rs1i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op("random", f3, pool[$urandom_range(0, 5)], $urandom, rs1i, rd,
            $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
    bus.req_valid    = 1'b0;
    bus.req_funct3   = 3'b000;
    bus.req_csr_addr = 12'h0;
    bus.req_rs1_data = 32'h0;
    bus.req_rs1_idx  = 5'd0;
    bus.req_rd_idx   = 5'd0;
    bus.resp_ready   = 1'b0;

    test_reset();
    test_directed();
    test_read_only();
    test_backpressure();
    test_reset_in_write();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR register-file interface.
- Accepts one decoded Zicsr instruction at a time (CSRRW/S/C and immediate forms) over a valid/ready handshake.
- Drives the file's read address, then performs the read-modify-write through its write port.
- Returns the old CSR value to the integer pipeline's writeback stage; sits between the execute stage and the CSR file.

Parameters:
XLEN, 32, CSR data width
CSR_AW, 12, CSR address width
RO_CHECK, 1, when 1, writes to addresses with addr[11:10]==2'b11 are illegal

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_funct3  in  3  Zicsr funct3
req_csr_addr  in  CSR_AW  target CSR
req_rs1_data  in  XLEN  rs1 value (register forms)
req_rs1_idx  in  5  rs1 index, or zimm for immediate forms
req_rd_idx  in  5  destination register
csr_addr  out  CSR_AW  read address to CSR file
csr_data  in  XLEN  combinational read data from CSR file
csr_write_en  out  1  CSR file write strobe
csr_wb_addr  out  CSR_AW  write address
csr_wb_data  out  XLEN  write data
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rd_idx  out  5  destination register
resp_rd_data  out  XLEN  old CSR value
resp_rd_we  out  1  integer register write enable
resp_illegal  out  1  illegal-instruction flag

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 except req_ready; all latched fields cleared.
- Unit is fully registered. csr_addr is driven from the latched address register.
- Any in-flight operation is abandoned on reset, including a pending write; csr_write_en drops immediately.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch funct3, addr, rd_idx, and operand; go to READ.
  - Operand is {27'b0,req_rs1_idx} when funct3[2]=1, else req_rs1_data.
- READ:
  - Sample csr_data into old_q.
  - Compute new = op (funct3[1:0]=01), old|op (10), or old&~op (11).
  - write_intent = (funct3[1:0]==01) or (latched rs1_idx/zimm != 0).
  - illegal = (funct3[1:0]==00) or (RO_CHECK && write_intent && addr[11:10]==2'b11).
  - Go to WRITE if write_intent && !illegal, else RESP.
- WRITE:
  - csr_write_en=1 for exactly this one cycle; csr_wb_addr=latched addr, csr_wb_data=new. The file commits on the falling edge within this cycle.
  - Go to RESP.
- RESP:
  - resp_valid=1, resp_rd_data=old_q, resp_rd_idx=latched rd.
  - resp_rd_we = !illegal && rd!=0; resp_illegal=illegal.
  - Hold all response outputs stable until resp_ready, then go to IDLE.
- req_ready=0 in every state except IDLE; there is no request pipelining. The next acceptance is at the earliest on the cycle after the response handshake.
- Latency, counted from the accept edge N:
  - with write: csr_write_en high in cycle N+2, resp_valid in cycle N+3;
  - without write or illegal: resp_valid in cycle N+2.
- csr_write_en is 0 outside WRITE. csr_wb_addr/csr_wb_data hold their last values.
- Arithmetic is bitwise only; no width extension beyond zimm zero-extension.
- rd==0 suppresses resp_rd_we only. The CSR read, write, and side effects still occur.

Decomposition:
- Shared package csr_pkg:
  - funct3 constants (CSRRW=001, CSRRS=010, CSRRC=011, CSRRWI=101, CSRRSI=110, CSRRCI=111);
  - FSM state encoding;
  - read-only address-field constant 2'b11.
- One combinational sub-module, csr_alu: (funct3, old, op) -> new, write_intent. The FSM stays in the top module.

Test Plan:
- CSRRW addr 0x340, rs1_data 0xDEADBEEF, rd 5; file holds 0x12345678 -> write 0xDEADBEEF to 0x340 at N+2; resp rd_data 0x12345678, rd_we=1 at N+3.
- CSRRS addr 0x300, rs1_idx 0 (any rs1_data) -> no csr_write_en pulse; resp at N+2 with old value, rd_we=1.
- CSRRCI addr 0x300, zimm 0x5, old 0xFF -> write 0xFA; CSRRSI zimm 0x3, old 0x10 -> write 0x13.
- CSRRW addr 0xC00 with RO_CHECK=1 -> no write; resp_illegal=1, rd_we=0. CSRRS addr 0xC00 with rs1_idx 0 -> legal read.
- Hold resp_ready=0 for 4 cycles -> resp outputs stable, req_ready=0 throughout; after the handshake, req_ready=1 the next cycle.
- Assert rst low during WRITE -> csr_write_en=0 immediately, state IDLE, resp_valid=0; the file is not updated.
